alu_sequencer: RTL and testbench
================================

# alu_sequencer

Control sequencer for the 8-bit accumulator ALU datapath. Accepts one ALU micro-instruction at a time over a valid/ready handshake, fetches the operand from the selected source (immediate, register or memory), drives the ALU control lines, and returns the resulting accumulator and flags on a valid/ready response channel. It sits between the instruction decode logic and the ALU datapath's control inputs (`data_src`, operand buses, `op`, `ce_a`, `ce_cy`).

## Interface
Parameters:
- `WIDTH`, 8, datapath width; must match the ALU.
- `ADDR_W`, 8, memory address width.
- `MEM_TIMEOUT`, 15, maximum cycles to wait for `mem_rvalid`; must be at least 1.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; synchronous, active-high.
- `instr_valid`  in  1  instruction offered.
- `instr_ready`  out  1  sequencer can accept.
- `instr_src`  in  `data_src_t`  operand source.
- `instr_op`  in  3  ALU operation.
- `instr_upd_cy`  in  1  instruction writes the carry flag.
- `instr_operand`  in  WIDTH  immediate or register value; ignored for memory source.
- `instr_addr`  in  ADDR_W  memory address; memory source only.
- `mem_req`  out  1  memory read request.
- `mem_addr`  out  ADDR_W  read address.
- `mem_rvalid`  in  1  read data valid.
- `mem_rdata`  in  WIDTH  read data.
- `data_src`, `immediate`, `reg_out`, `mem_out`, `op`, `ce_a`, `ce_cy`  out  (ALU widths)  ALU controls.
- `acc_v`  in  WIDTH  registered accumulator value from the ALU.
- `flag_cy`, `flag_z`, `flag_s`, `flag_o`  in  1 each  ALU flags.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer takes the result.
- `resp_acc`  out  WIDTH  accumulator snapshot.
- `resp_flags`  out  4  {cy, z, s, o} snapshot.
- `resp_err`  out  1  memory timeout; ALU not updated.

## Operation
- FSM states: IDLE, MEM_WAIT, EXEC, RESP.
- IDLE: `instr_ready`=1. On `instr_valid`, latch all `instr_*` fields.
  - Memory source: go to MEM_WAIT.
  - Immediate or register source: go to EXEC.
- MEM_WAIT:
  - `mem_req`=1 and `mem_addr`=latched address, both held every cycle in this state.
  - The timeout counter increments each cycle.
  - On `mem_rvalid`: capture `mem_rdata` into the operand register and go to EXEC.
  - If the counter reaches MEM_TIMEOUT-1 without `mem_rvalid`: go to RESP with the error latched.
- EXEC (exactly one cycle):
  - `data_src`=latched source; `op`=latched op.
  - The operand is driven on `immediate`, `reg_out` or `mem_out` according to the source. Unused operand buses are 0.
  - `ce_a`=1; `ce_cy`=`instr_upd_cy`. Then go to RESP.
- RESP:
  - `resp_valid`=1.
  - `resp_acc` and `resp_flags` are sampled from `acc_v` and the flags on the first cycle of RESP, then held stable.
  - `resp_err` is held stable.
  - On `resp_ready`: go to IDLE.
- Outside EXEC: `ce_a`=0, `ce_cy`=0, operand buses 0, `data_src`=DS_IMM, `op`=0.
- A `mem_rvalid` that arrives outside MEM_WAIT is ignored.
- On timeout: `ce_a` is never asserted and `resp_err`=1. On success `resp_err`=0.

## Timing
- Reset values: state IDLE; `instr_ready`=1; `mem_req`=0; `ce_a`/`ce_cy`=0; all buses 0; `data_src`=DS_IMM; `resp_valid`=0; `resp_err`=0.
- Reset asserted in any state returns to IDLE on the next edge. Any in-flight instruction is dropped and no `ce_a` pulse is issued.
- Immediate/register latency: handshake at cycle 0; EXEC at cycle 1; `resp_valid` at cycle 2.
- Memory latency: handshake at cycle 0; MEM_WAIT from cycle 1; `rvalid` at cycle k; EXEC at k+1; RESP at k+2.
  - A `mem_rvalid` in the same cycle the counter hits the limit wins; no timeout is flagged.
- Throughput: one instruction per (latency + 1) cycles. `instr_ready` is 0 from MEM_WAIT through RESP.
- RESP with `resp_ready` held at 1 lasts one cycle. The next instruction can be accepted in the following cycle.

## Structure
- Shared `enums` package:
  - `data_src_t` with DS_MEM=2'b00, DS_IMM=2'b01, DS_REG=2'b11.
  - A new `seq_state_t` enum.
  - ALU op code constants.
- Single module; the timeout counter stays inline.
- The flag snapshot order {cy, z, s, o} is a package constant.

## Test plan
- Immediate ADD: `instr_src`=DS_IMM, operand 8'h05, `instr_upd_cy`=1.
  - Exactly one `ce_a`=`ce_cy`=1 cycle, at cycle 1, with `immediate`=8'h05.
  - `resp_valid` at cycle 2; `resp_acc` matches the ALU model.
- Register operand with `resp_ready` held 0 for 5 cycles.
  - `resp_*` stable throughout; `instr_ready`=0 throughout; no extra `ce_a`.
- Memory read with `mem_rvalid` after 3 cycles, `mem_rdata`=8'hA5.
  - `mem_req` high for 3 cycles with `mem_addr` correct.
  - `mem_out`=8'hA5 in EXEC; `resp_err`=0.
- Memory timeout: `mem_rvalid` never asserted.
  - `mem_req` for exactly MEM_TIMEOUT cycles.
  - `resp_err`=1; `ce_a` never high; `acc_v` unchanged.
- Reset mid-operation: `rst` pulsed in MEM_WAIT and, separately, in EXEC.
  - Next cycle: IDLE, all outputs at reset values, `instr_ready`=1.
- Back-to-back: 3 immediate instructions with `resp_ready`=1.
  - Accepted every 3 cycles; `acc_v` sequence matches the model.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared types and constants for the accumulator-ALU control sequencer.
// Operand-source encoding, sequencer states, ALU op codes and flag snapshot layout.
package alu_sequencer_pkg;

    typedef enum logic [1:0] {
        DS_MEM = 2'b00,
        DS_IMM = 2'b01,
        DS_REG = 2'b11
    } data_src_t;

    typedef enum logic [1:0] {
        StIdle,
        StMemWait,
        StExec,
        StResp
    } seq_state_t;

    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_ADC = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_LD  = 3'd6;
    localparam logic [2:0] OP_NOP = 3'd7;

    // Flag snapshot layout: {cy, z, s, o}
    localparam int unsigned FLAGS_W = 4;
    localparam int unsigned FLAG_CY = 3;
    localparam int unsigned FLAG_Z  = 2;
    localparam int unsigned FLAG_S  = 1;
    localparam int unsigned FLAG_O  = 0;

    function automatic logic [FLAGS_W-1:0] pack_flags(input logic cy, input logic z,
                                                      input logic s, input logic o);
        logic [FLAGS_W-1:0] f;
        f          = '0;
        f[FLAG_CY] = cy;
        f[FLAG_Z]  = z;
        f[FLAG_S]  = s;
        f[FLAG_O]  = o;
        return f;
    endfunction

endpackage

// File: rtl/alu_sequencer.sv
// Sequences one ALU micro-instruction: operand fetch (imm/reg/mem with timeout),
// a single-cycle ALU enable, then a held accumulator/flag response.
module alu_sequencer
    import alu_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH       = 8,
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                instr_valid_i,
    output logic                instr_ready_o,
    input  data_src_t           instr_src_i,
    input  logic [2:0]          instr_op_i,
    input  logic                instr_upd_cy_i,
    input  logic [WIDTH-1:0]    instr_operand_i,
    input  logic [ADDR_W-1:0]   instr_addr_i,
    output logic                mem_req_o,
    output logic [ADDR_W-1:0]   mem_addr_o,
    input  logic                mem_rvalid_i,
    input  logic [WIDTH-1:0]    mem_rdata_i,
    output data_src_t           data_src_o,
    output logic [WIDTH-1:0]    immediate_o,
    output logic [WIDTH-1:0]    reg_out_o,
    output logic [WIDTH-1:0]    mem_out_o,
    output logic [2:0]          op_o,
    output logic                ce_a_o,
    output logic                ce_cy_o,
    input  logic [WIDTH-1:0]    acc_v_i,
    input  logic                flag_cy_i,
    input  logic                flag_z_i,
    input  logic                flag_s_i,
    input  logic                flag_o_i,
    output logic                resp_valid_o,
    input  logic                resp_ready_i,
    output logic [WIDTH-1:0]    resp_acc_o,
    output logic [FLAGS_W-1:0]  resp_flags_o,
    output logic                resp_err_o
);

    localparam int unsigned CntW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(MEM_TIMEOUT - 1);

    seq_state_t          state_q, state_d;
    data_src_t           src_q, src_d;
    logic [2:0]          op_q, op_d;
    logic                upd_cy_q, upd_cy_d;
    logic [WIDTH-1:0]    operand_q, operand_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CntW-1:0]     cnt_q, cnt_d;
    logic                err_q, err_d;
    logic                first_q, first_d;
    logic [WIDTH-1:0]    resp_acc_q, resp_acc_d;
    logic [FLAGS_W-1:0]  resp_flags_q, resp_flags_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= StIdle;
            src_q        <= DS_IMM;
            op_q         <= '0;
            upd_cy_q     <= 1'b0;
            operand_q    <= '0;
            addr_q       <= '0;
            cnt_q        <= '0;
            err_q        <= 1'b0;
            first_q      <= 1'b0;
            resp_acc_q   <= '0;
            resp_flags_q <= '0;
        end else begin
            state_q      <= state_d;
            src_q        <= src_d;
            op_q         <= op_d;
            upd_cy_q     <= upd_cy_d;
            operand_q    <= operand_d;
            addr_q       <= addr_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            first_q      <= first_d;
            resp_acc_q   <= resp_acc_d;
            resp_flags_q <= resp_flags_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        src_d        = src_q;
        op_d         = op_q;
        upd_cy_d     = upd_cy_q;
        operand_d    = operand_q;
        addr_d       = addr_q;
        cnt_d        = cnt_q;
        err_d        = err_q;
        first_d      = 1'b0;
        resp_acc_d   = resp_acc_q;
        resp_flags_d = resp_flags_q;

        instr_ready_o = 1'b0;
        mem_req_o     = 1'b0;
        mem_addr_o    = '0;
        data_src_o    = DS_IMM;
        immediate_o   = '0;
        reg_out_o     = '0;
        mem_out_o     = '0;
        op_o          = OP_ADD;
        ce_a_o        = 1'b0;
        ce_cy_o       = 1'b0;
        resp_valid_o  = 1'b0;
        resp_acc_o    = '0;
        resp_flags_o  = '0;
        resp_err_o    = 1'b0;

        case (state_q)
            StIdle: begin
                instr_ready_o = 1'b1;
                if (instr_valid_i) begin
                    src_d     = instr_src_i;
                    op_d      = instr_op_i;
                    upd_cy_d  = instr_upd_cy_i;
                    operand_d = instr_operand_i;
                    addr_d    = instr_addr_i;
                    cnt_d     = '0;
                    err_d     = 1'b0;
                    state_d   = (instr_src_i == DS_MEM) ? StMemWait : StExec;
                end
            end
            StMemWait: begin
                mem_req_o  = 1'b1;
                mem_addr_o = addr_q;
                // Data arriving on the final allowed cycle still counts as success.
                if (mem_rvalid_i) begin
                    operand_d = mem_rdata_i;
                    state_d   = StExec;
                end else if (cnt_q == CntLast) begin
                    err_d   = 1'b1;
                    first_d = 1'b1;
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StExec: begin
                // A reset landing in this cycle must not leak an ALU write.
                if (!rst_i) begin
                    data_src_o = src_q;
                    op_o       = op_q;
                    ce_a_o     = 1'b1;
                    ce_cy_o    = upd_cy_q;
                    case (src_q)
                        DS_MEM:  mem_out_o   = operand_q;
                        DS_REG:  reg_out_o   = operand_q;
                        default: immediate_o = operand_q;
                    endcase
                end
                first_d = 1'b1;
                state_d = StResp;
            end
            StResp: begin
                resp_valid_o = 1'b1;
                resp_err_o   = err_q;
                if (first_q) begin
                    resp_acc_d   = acc_v_i;
                    resp_flags_d = pack_flags(flag_cy_i, flag_z_i, flag_s_i, flag_o_i);
                    resp_acc_o   = resp_acc_d;
                    resp_flags_o = resp_flags_d;
                end else begin
                    resp_acc_o   = resp_acc_q;
                    resp_flags_o = resp_flags_q;
                end
                if (resp_ready_i) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: a behavioural accumulator ALU closes the loop,
// a reference model predicts each response and a monitor checks what the DUT returns.
module tb_alu_sequencer;
    import alu_sequencer_pkg::*;

    localparam int unsigned MT = 15;

    logic       clk = 1'b0;
    logic       rst;
    logic       instr_valid, instr_ready, instr_upd_cy;
    data_src_t  instr_src, data_src;
    logic [2:0] instr_op, op;
    logic [7:0] instr_operand, instr_addr, mem_addr, mem_rdata;
    logic       mem_req, mem_rvalid;
    logic [7:0] immediate, reg_out, mem_out, acc_v, resp_acc;
    logic       ce_a, ce_cy, flag_cy, flag_z, flag_s, flag_o;
    logic       resp_valid, resp_ready, resp_err;
    logic [3:0] resp_flags;

    always #5 clk = ~clk;

    alu_sequencer #(.WIDTH(8), .ADDR_W(8), .MEM_TIMEOUT(MT)) dut (
        .clk_i(clk), .rst_i(rst),
        .instr_valid_i(instr_valid), .instr_ready_o(instr_ready),
        .instr_src_i(instr_src), .instr_op_i(instr_op), .instr_upd_cy_i(instr_upd_cy),
        .instr_operand_i(instr_operand), .instr_addr_i(instr_addr),
        .mem_req_o(mem_req), .mem_addr_o(mem_addr),
        .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata),
        .data_src_o(data_src), .immediate_o(immediate), .reg_out_o(reg_out),
        .mem_out_o(mem_out), .op_o(op), .ce_a_o(ce_a), .ce_cy_o(ce_cy),
        .acc_v_i(acc_v), .flag_cy_i(flag_cy), .flag_z_i(flag_z), .flag_s_i(flag_s),
        .flag_o_i(flag_o),
        .resp_valid_o(resp_valid), .resp_ready_i(resp_ready), .resp_acc_o(resp_acc),
        .resp_flags_o(resp_flags), .resp_err_o(resp_err)
    );

    typedef struct packed {
        logic [7:0] acc;
        logic       cy, z, s, o;
    } alu_st_t;

    typedef struct packed {
        logic [7:0] acc;
        logic [3:0] flags;
        logic       err;
    } exp_t;

    function automatic alu_st_t alu_step(input alu_st_t st, input logic [2:0] opc,
                                         input logic [7:0] b, input logic upd_cy);
        logic [8:0] r;
        logic       cy_n, o_n;
        alu_st_t    n;
        cy_n = 1'b0;
        o_n  = 1'b0;
        case (opc)
            OP_ADD: begin
                r = {1'b0, st.acc} + {1'b0, b};
                cy_n = r[8];
                o_n = (st.acc[7] == b[7]) && (r[7] != st.acc[7]);
            end
            OP_ADC: begin
                r = {1'b0, st.acc} + {1'b0, b} + {8'd0, st.cy};
                cy_n = r[8];
                o_n = (st.acc[7] == b[7]) && (r[7] != st.acc[7]);
            end
            OP_SUB: begin
                r = {1'b0, st.acc} - {1'b0, b};
                cy_n = r[8];
                o_n = (st.acc[7] != b[7]) && (r[7] != st.acc[7]);
            end
            OP_AND:  r = {1'b0, st.acc & b};
            OP_OR:   r = {1'b0, st.acc | b};
            OP_XOR:  r = {1'b0, st.acc ^ b};
            OP_LD:   r = {1'b0, b};
            default: r = {1'b0, st.acc};
        endcase
        n.acc = r[7:0];
        n.z   = (r[7:0] == 8'd0);
        n.s   = r[7];
        n.o   = o_n;
        n.cy  = upd_cy ? cy_n : st.cy;
        return n;
    endfunction

    // Stand-in for the ALU datapath: registered accumulator driven by the control lines.
    alu_st_t alu = '0;
    logic [7:0] sel_bus;
    assign sel_bus = (data_src == DS_MEM) ? mem_out : (data_src == DS_REG) ? reg_out : immediate;
    always @(posedge clk) if (ce_a) alu <= alu_step(alu, op, sel_bus, ce_cy);
    assign acc_v   = alu.acc;
    assign flag_cy = alu.cy;
    assign flag_z  = alu.z;
    assign flag_s  = alu.s;
    assign flag_o  = alu.o;

    int n_checks = 0;
    int n_err = 0;
    int cyc = 0;
    int ce_a_cnt = 0;
    int mem_req_cnt = 0;
    int last_acc = 0;
    exp_t sb_q[$];
    alu_st_t model = '0;
    data_src_t exp_src = DS_IMM;
    logic [2:0] exp_op = '0;
    logic exp_upd = 1'b0;
    logic [7:0] exp_addr = '0;
    logic [23:0] exp_bus = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pops the scoreboard on each new response and checks control lines.
    logic in_resp = 1'b0;
    logic [12:0] held = '0;
    exp_t e;
    always @(negedge clk) begin
        if (ce_a) ce_a_cnt++;
        if (mem_req) mem_req_cnt++;
        if (rst) begin
            in_resp = 1'b0;
        end else begin
            if (!ce_a) begin
                chk("idle_ctrl", {ce_cy, data_src, op, immediate, reg_out, mem_out},
                    {1'b0, DS_IMM, 3'd0, 24'd0});
            end else begin
                chk("exec_ctrl", {data_src, op, ce_cy}, {exp_src, exp_op, exp_upd});
                chk("exec_bus", {immediate, reg_out, mem_out}, exp_bus);
            end
            if (mem_req) chk("mem_addr", mem_addr, exp_addr);
            if (resp_valid) begin
                if (!in_resp) begin
                    if (sb_q.size() == 0) begin
                        chk("sb_underflow", 32'(sb_q.size()), 1);
                    end else begin
                        e = sb_q.pop_front();
                        chk("resp_acc", resp_acc, e.acc);
                        chk("resp_flags", resp_flags, e.flags);
                        chk("resp_err", resp_err, e.err);
                    end
                    held = {resp_acc, resp_flags, resp_err};
                    in_resp = 1'b1;
                end else begin
                    chk("resp_stable", {resp_acc, resp_flags, resp_err}, held);
                end
                if (resp_ready) in_resp = 1'b0;
            end
        end
    end

    task automatic drive_instr(input data_src_t src, input logic [2:0] opc, input logic upd,
                               input logic [7:0] opnd, input logic [7:0] addr);
        instr_valid   = 1'b1;
        instr_src     = src;
        instr_op      = opc;
        instr_upd_cy  = upd;
        instr_operand = opnd;
        instr_addr    = addr;
        exp_src       = src;
        exp_op        = opc;
        exp_upd       = upd;
        exp_addr      = addr;
    endtask

    task automatic idle_inputs();
        instr_valid   = 1'b0;
        instr_src     = DS_IMM;
        instr_op      = 3'($urandom);
        instr_upd_cy  = 1'($urandom);
        instr_operand = 8'($urandom);
        instr_addr    = 8'($urandom);
    endtask

    // k: cycle after handshake on which mem_rvalid pulses (0 = never).
    task automatic run_instr(input data_src_t src, input logic [2:0] opc, input logic upd,
                             input logic [7:0] val, input logic [7:0] addr,
                             input logic [7:0] mdata, input int k, input int ready_at,
                             input bit chk_gap);
        bit timeout, done, busy_ok;
        logic [7:0] eff;
        int ce0, mr0, resp_c, exp_resp, exp_mr;
        chk("instr_ready_idle", instr_ready, 1);
        timeout = (src == DS_MEM) && (k == 0 || k > MT);
        eff = (src == DS_MEM) ? mdata : val;
        drive_instr(src, opc, upd, (src == DS_MEM) ? 8'($urandom) : val, addr);
        exp_bus = (src == DS_MEM) ? {16'd0, eff} : (src == DS_REG) ? {8'd0, eff, 8'd0}
                                                                    : {eff, 16'd0};
        if (!timeout) model = alu_step(model, opc, eff, upd);
        sb_q.push_back({model.acc, {model.cy, model.z, model.s, model.o}, timeout});
        if (chk_gap) chk("accept_gap", cyc - last_acc, 3);
        last_acc = cyc;
        ce0 = ce_a_cnt;
        mr0 = mem_req_cnt;
        @(posedge clk); #1;
        idle_inputs();
        done = 1'b0;
        busy_ok = 1'b1;
        resp_c = 0;
        for (int c = 1; c <= 48 && !done; c++) begin
            mem_rvalid = (k == c);
            mem_rdata  = (k == c) ? mdata : 8'($urandom);
            resp_ready = (c >= ready_at);
            @(negedge clk);
            if (instr_ready) busy_ok = 1'b0;
            if (resp_valid && resp_c == 0) resp_c = c;
            if (resp_valid && resp_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        mem_rvalid = 1'b0;
        resp_ready = 1'b0;
        exp_resp = timeout ? MT + 1 : (src == DS_MEM) ? k + 2 : 2;
        exp_mr   = timeout ? MT : (src == DS_MEM) ? k : 0;
        chk("resp_handshake", done, 1);
        chk("resp_latency", resp_c, exp_resp);
        chk("instr_ready_busy", busy_ok, 1);
        chk("mem_req_cycles", mem_req_cnt - mr0, exp_mr);
        chk("ce_a_pulses", ce_a_cnt - ce0, timeout ? 0 : 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ctrl"}, {instr_ready, mem_req, ce_a, ce_cy, resp_valid, resp_err},
            6'b100000);
        chk({tag, "_bus"}, {mem_addr, resp_acc, resp_flags, data_src, op},
            {8'd0, 8'd0, 4'd0, DS_IMM, 3'd0});
        chk({tag, "_alu"}, {immediate, reg_out, mem_out}, 24'd0);
    endtask

    task automatic reset_in(input bit in_exec);
        drive_instr(in_exec ? DS_IMM : DS_MEM, 3'($urandom), 1'b1, 8'($urandom),
                    8'($urandom));
        @(posedge clk); #1;
        idle_inputs();
        if (!in_exec) begin
            @(posedge clk); #1;
            chk("rst_pre_memwait", mem_req, 1);
        end
        rst = 1'b1;
        @(negedge clk);
        if (in_exec) chk("rst_exec_no_ce_a", ce_a, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs(in_exec ? "rst_exec" : "rst_memwait");
        chk("rst_acc_kept", acc_v, model.acc);
        @(posedge clk); #1;
    endtask

    initial begin
        data_src_t s;
        int k;
        rst = 1'b1;
        mem_rvalid = 1'b0;
        mem_rdata = '0;
        resp_ready = 1'b0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_reset_outputs("reset");
        @(posedge clk); #1;

        run_instr(DS_IMM, OP_ADD, 1'b1, 8'h05, 8'h00, 8'h00, 0, 1, 1'b0);
        run_instr(DS_REG, OP_SUB, 1'b1, 8'h37, 8'h00, 8'h00, 0, 7, 1'b0);
        run_instr(DS_MEM, OP_ADD, 1'b1, 8'h00, 8'h3C, 8'hA5, 3, 1, 1'b0);
        run_instr(DS_MEM, OP_ADD, 1'b1, 8'h00, 8'h81, 8'h11, 0, 1, 1'b0);
        run_instr(DS_MEM, OP_XOR, 1'b0, 8'h00, 8'hF0, 8'h5A, MT, 2, 1'b0);
        run_instr(DS_MEM, OP_LD, 1'b0, 8'h00, 8'h07, 8'h80, 1, 1, 1'b0);
        reset_in(1'b0);
        reset_in(1'b1);
        run_instr(DS_IMM, OP_ADC, 1'b1, 8'h7F, 8'h00, 8'h00, 0, 1, 1'b0);
        run_instr(DS_IMM, OP_ADD, 1'b1, 8'h81, 8'h00, 8'h00, 0, 1, 1'b1);
        run_instr(DS_IMM, OP_OR, 1'b0, 8'h0F, 8'h00, 8'h00, 0, 1, 1'b1);

        for (int i = 0; i < 40; i++) begin
            case ($urandom_range(0, 2))
                0: s = DS_IMM;
                1: s = DS_REG;
                default: s = DS_MEM;
            endcase
            if (s == DS_MEM) k = ($urandom_range(0, 7) == 0) ? 0 : $urandom_range(1, MT);
            else k = $urandom_range(0, 3);
            run_instr(s, 3'($urandom), 1'($urandom), 8'($urandom), 8'($urandom),
                      8'($urandom), k, $urandom_range(1, 4), 1'b0);
        end

        repeat (2) @(posedge clk);
        chk("sb_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
